// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master (sclk idles low, data sampled on sclk rise),
// MSB first, 8-bit frames, sclk half-period of CLK_DIV system clocks.
// Optional build macro SPI_MASTER_BURST_EN: a start request present when the
// last sclk-high half ends chains the next frame directly, keeping cs low.
//
// Handshake: i_start is sampled only while the FSM is idle (o_busy low); the
// cycle it is seen, i_tx_data is latched and o_busy rises. o_busy stays high
// until the edge that pulses o_done for one cycle, at which o_rx_data updates.
// A start seen while busy is dropped, never queued (except the chaining case
// when SPI_MASTER_BURST_EN is defined).
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rx_data,
  output logic       o_sclk,
  output logic       o_cs,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

`ifdef SPI_MASTER_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_div;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_tx_sr;   // remaining tx bits; bit 7 goes straight to mosi
  logic [7:0] r_rx_sr;
  logic       r_cs;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rx_data;

  logic       w_tick;
  logic       w_chain;
  logic       w_accept;
  logic       w_rise;
  logic       w_shift;
  logic       w_rx_load;
  logic       w_cs_d;
  logic       w_sclk_d;
  logic       w_mosi_d;
  logic       w_busy_d;
  logic       w_done_d;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_chain = BURST_EN & i_start;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: each active state lasts one sclk half-period
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_LO;
      S_LO:   if (w_tick) w_state_nxt = S_HI;
      S_HI: begin
        if (w_tick) begin
          if (r_bit_cnt != 3'd7) w_state_nxt = S_LO;
          else if (w_chain)      w_state_nxt = S_LO;
          else                   w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: if (w_tick) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: transition strobes and next values of the output registers
  always_comb begin
    w_accept  = 1'b0;
    w_rise    = 1'b0;
    w_shift   = 1'b0;
    w_rx_load = 1'b0;
    w_cs_d    = r_cs;
    w_sclk_d  = r_sclk;
    w_mosi_d  = r_mosi;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_cs_d   = 1'b0;
          w_mosi_d = i_tx_data[7];
          w_busy_d = 1'b1;
        end
      end
      S_LO: begin
        if (w_tick) begin
          w_rise   = 1'b1;
          w_sclk_d = 1'b1;
        end
      end
      S_HI: begin
        if (w_tick) begin
          w_sclk_d = 1'b0;
          if (r_bit_cnt != 3'd7) begin
            w_shift  = 1'b1;
            w_mosi_d = r_tx_sr[6];
          end else if (w_chain) begin
            // chained frame: finish this one and load the next in one edge
            w_accept  = 1'b1;
            w_done_d  = 1'b1;
            w_rx_load = 1'b1;
            w_mosi_d  = i_tx_data[7];
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_cs_d    = 1'b1;
          w_mosi_d  = 1'b0;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_rx_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Divider: counts 0..CLK_DIV-1 within each half-period, parked at 0 when idle
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == S_IDLE) r_div <= 8'd0;
    else if (w_tick)                r_div <= 8'd0;
    else                            r_div <= r_div + 8'd1;
  end

  // Shift registers and bit counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_sr   <= 7'd0;
      r_rx_sr   <= 8'd0;
      r_bit_cnt <= 3'd0;
    end else begin
      if (w_accept) begin
        r_tx_sr   <= i_tx_data[6:0];
        r_bit_cnt <= 3'd0;
      end else if (w_shift) begin
        r_tx_sr   <= {r_tx_sr[5:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_rise) r_rx_sr <= {r_rx_sr[6:0], i_miso};
    end
  end

  // Output registers: every port is driven from a flop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= 8'd0;
    end else begin
      r_cs   <= w_cs_d;
      r_sclk <= w_sclk_d;
      r_mosi <= w_mosi_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      if (w_rx_load) r_rx_data <= r_rx_sr;
    end
  end

  assign o_cs      = r_cs;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;
  assign o_state   = r_state;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master. Two instances (CLK_DIV=2 and 1) share
// the stimulus; tb_sel chooses which one is driven and observed.
module tb_spi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tb_start;
  logic       tb_sel;        // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic       tb_loop;       // 1: miso tied to mosi, 0: modelled slave
  logic       tb_slave_bit;
  logic [7:0] tb_tx;

  logic       busy0, done0, sclk0, cs0, mosi0;
  logic [7:0] rx0;
  logic [1:0] st0;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rx1;
  logic [1:0] st1;

  logic       w_start0, w_start1, w_miso;
  logic       w_busy, w_done, w_sclk, w_cs, w_mosi;
  logic [7:0] w_rx;

  assign w_start0 = tb_start & ~tb_sel;
  assign w_start1 = tb_start &  tb_sel;
  assign w_busy   = tb_sel ? busy1 : busy0;
  assign w_done   = tb_sel ? done1 : done0;
  assign w_sclk   = tb_sel ? sclk1 : sclk0;
  assign w_cs     = tb_sel ? cs1   : cs0;
  assign w_mosi   = tb_sel ? mosi1 : mosi0;
  assign w_rx     = tb_sel ? rx1   : rx0;
  assign w_miso   = tb_loop ? w_mosi : tb_slave_bit;

  spi_master #(.CLK_DIV(2)) u_dut_d2 (
    .i_clk(clk), .i_rst(rst), .i_start(w_start0), .i_tx_data(tb_tx),
    .o_busy(busy0), .o_done(done0), .o_rx_data(rx0), .o_sclk(sclk0),
    .o_cs(cs0), .o_mosi(mosi0), .i_miso(w_miso), .o_state(st0)
  );

  spi_master #(.CLK_DIV(1)) u_dut_d1 (
    .i_clk(clk), .i_rst(rst), .i_start(w_start1), .i_tx_data(tb_tx),
    .o_busy(busy1), .o_done(done1), .o_rx_data(rx1), .o_sclk(sclk1),
    .o_cs(cs1), .o_mosi(mosi1), .i_miso(w_miso), .o_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // One frame. Expected timing comes from the SPI rules: with half-period d,
  // cs low for 17*d cycles, rise k at (2k+1)*d, done at 17*d after T0.
  // poke_at: edge (after T0) at which a spurious start with tx=0 is presented.
  // rst_at : edge (after T0) at which reset is applied.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] slv, input logic loop,
                           input logic sel, input int poke_at, input int rst_at,
                           input logic [7:0] exp_rx, input int exp_dones);
    int d, win, cs_low, rises, edge_err, done_cnt, done_at, falls;
    logic [7:0] mosi_bits, rx_at_done;
    logic prev_sclk;
    d = sel ? 1 : 2;
    win = 17 * d + 4;
    cs_low = 0; rises = 0; edge_err = 0; done_cnt = 0; done_at = -1; falls = 0;
    mosi_bits = 8'd0; rx_at_done = 8'd0; prev_sclk = 1'b0;
    @(negedge clk);
    tb_sel = sel; tb_loop = loop; tb_slave_bit = slv[7]; tb_tx = tx; tb_start = 1'b1;
    @(posedge clk);  // T0
    for (int n = 0; n <= win; n++) begin
      @(negedge clk);
      if (n == 0) tb_start = 1'b0;
      if (!w_cs) cs_low++;
      if (w_sclk && !prev_sclk) begin
        if (n != (2 * rises + 1) * d) edge_err++;
        mosi_bits = {mosi_bits[6:0], w_mosi};
        rises++;
      end
      if (!w_sclk && prev_sclk) begin
        falls++;
        if (falls < 8) tb_slave_bit = slv[7 - falls];
      end
      prev_sclk = w_sclk;
      if (w_done) begin
        done_cnt++;
        done_at = n;
        rx_at_done = w_rx;
      end
      if (poke_at > 0 && n == poke_at - 1) begin
        tb_start = 1'b1;
        tb_tx = 8'h00;
      end
      if (poke_at > 0 && n == poke_at) tb_start = 1'b0;
      if (rst_at > 0 && n == rst_at - 1) rst = 1'b1;
      if (rst_at > 0 && n == rst_at) begin
        check("rst_mid_outputs", {w_cs, w_sclk, w_busy, w_done, w_rx}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
      end
    end
    check("done_count", done_cnt, exp_dones);
    if (exp_dones == 1) begin
      check("done_time", done_at, 17 * d);
      check("rx_data", rx_at_done, exp_rx);
      check("mosi_bits", mosi_bits, tx);
      check("sclk_rises", rises, 8);
      check("sclk_edge_timing", edge_err, 0);
      check("cs_low_cycles", cs_low, 17 * d);
      check("idle_after", {w_busy, w_cs, w_sclk}, {1'b0, 1'b1, 1'b0});
    end
    if (rst_at > 0) check("cs_low_before_rst", cs_low, rst_at);
  endtask

  // Two frames requested back to back in loopback on the CLK_DIV=2 instance.
  task automatic run_b2b(input logic [7:0] tx1, input logic [7:0] tx2);
    int d, t2, d1, d2, win, cs_low, rises, edge_err, done_cnt, exp_n;
    int done_n[2];
    logic [7:0] done_rx[2];
    logic [15:0] mosi_bits;
    logic prev_sclk;
    d = 2;
`ifdef SPI_MASTER_BURST_EN
    t2 = 16 * d;       // next frame chained at the last falling edge
    d1 = 16 * d;
`else
    t2 = 17 * d + 1;   // next start accepted the cycle after done
    d1 = 17 * d;
`endif
    d2 = t2 + 17 * d;
    win = d2 + 4;
    cs_low = 0; rises = 0; edge_err = 0; done_cnt = 0; mosi_bits = 16'd0; prev_sclk = 1'b0;
    done_n[0] = -1; done_n[1] = -1; done_rx[0] = 8'd0; done_rx[1] = 8'd0;
    @(negedge clk);
    tb_sel = 1'b0; tb_loop = 1'b1; tb_tx = tx1; tb_start = 1'b1;
    @(posedge clk);  // T0
    for (int n = 0; n <= win; n++) begin
      @(negedge clk);
      if (n == 0) tb_tx = tx2;
      if (n == t2) tb_start = 1'b0;
      if (!w_cs) cs_low++;
      if (w_sclk && !prev_sclk) begin
        exp_n = (rises < 8) ? (2 * rises + 1) * d : t2 + (2 * (rises - 8) + 1) * d;
        if (n != exp_n) edge_err++;
        mosi_bits = {mosi_bits[14:0], w_mosi};
        rises++;
      end
      prev_sclk = w_sclk;
      if (w_done) begin
        if (done_cnt < 2) begin
          done_n[done_cnt] = n;
          done_rx[done_cnt] = w_rx;
        end
        done_cnt++;
      end
    end
    check("b2b_done_count", done_cnt, 2);
    check("b2b_done0_time", done_n[0], d1);
    check("b2b_done1_time", done_n[1], d2);
    check("b2b_rx0", done_rx[0], tx1);
    check("b2b_rx1", done_rx[1], tx2);
    check("b2b_mosi_bits", mosi_bits, {tx1, tx2});
    check("b2b_sclk_rises", rises, 16);
    check("b2b_edge_timing", edge_err, 0);
    check("b2b_cs_low_cycles", cs_low, d2 - (t2 - d1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic       loop;
    logic       sel;
    int         poke_at;
    int         rst_at;
    logic [7:0] exp_rx;
    int         exp_dones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] r_tx, r_slv;
    logic r_loop, r_sel;

    vecs[0] = '{8'hA5, 8'h00, 1'b1, 1'b0, -1, -1, 8'hA5, 1};  // loopback, div 2
    vecs[1] = '{8'hF0, 8'h3C, 1'b0, 1'b1, -1, -1, 8'h3C, 1};  // slave pattern, div 1
    vecs[2] = '{8'hA5, 8'h00, 1'b1, 1'b0, 10, -1, 8'hA5, 1};  // start while busy
    vecs[3] = '{8'h5A, 8'h00, 1'b1, 1'b0, -1,  9, 8'h00, 0};  // reset mid-frame
    vecs[4] = '{8'hC3, 8'h00, 1'b1, 1'b0, -1, -1, 8'hC3, 1};  // recovers after reset
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, -1, -1, 8'hFF, 1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 1'b1, -1, -1, 8'h00, 1};

    rst = 1'b1; tb_start = 1'b0; tb_sel = 1'b0; tb_loop = 1'b1;
    tb_slave_bit = 1'b0; tb_tx = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_d2", {cs0, sclk0, mosi0, busy0, done0, rx0, st0}, {1'b1, 4'b0000, 8'h00, 2'd0});
    check("reset_d1", {cs1, sclk1, mosi1, busy1, done1, rx1, st1}, {1'b1, 4'b0000, 8'h00, 2'd0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].tx, vecs[i].slv, vecs[i].loop, vecs[i].sel,
                vecs[i].poke_at, vecs[i].rst_at, vecs[i].exp_rx, vecs[i].exp_dones);

    run_b2b(8'h81, 8'h7E);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      r_tx   = 8'($urandom_range(0, 255));
      r_slv  = 8'($urandom_range(0, 255));
      r_loop = 1'($urandom_range(0, 1));
      r_sel  = 1'($urandom_range(0, 1));
      run_frame(r_tx, r_slv, r_loop, r_sel, -1, -1, r_loop ? r_tx : r_slv, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
